// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler_if : requester/transmitter bundle around uart_tx_scheduler
// Revision: 1.0
// ============================================================================
interface uart_tx_scheduler_if #(
  parameter int N_REQ = 4
) ();

  localparam int c_GRANT_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]     req_valid;
  logic [8*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]     req_last;
  logic [N_REQ-1:0]     req_ready;
  logic                 tx_start;
  logic [7:0]           sdata;
  logic                 tx_busy;
  logic [c_GRANT_W-1:0] grant_id;
  logic                 sched_busy;

  // Requesters and the UART transmitter side
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, sdata, grant_id, sched_busy
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, sdata, grant_id, sched_busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// uart_tx_scheduler : round-robin sharing of one UART TX with message locking
// Revision: 1.0
// ============================================================================
module uart_tx_scheduler #(
  parameter int N_REQ            = 4,
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int LOCK_IDLE_CLKS   = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  uart_tx_scheduler_if.slave bus_if
);

  localparam int c_GRANT_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_FRAME_CLKS = CLK_PER_HALF_BIT * 20;
  localparam int c_CNT_W      = (c_FRAME_CLKS > 1) ? $clog2(c_FRAME_CLKS) : 1;

  localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(c_FRAME_CLKS - 1);
  localparam logic [c_GRANT_W-1:0] c_PTR_RST  = c_GRANT_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_GRANT_W-1:0] ptr_q, ptr_d;
  logic [c_GRANT_W-1:0] grant_q, grant_d;
  logic [c_GRANT_W-1:0] owner_q, owner_d;
  logic                 lock_q, lock_d;
  logic [7:0]           sdata_q, sdata_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;

  logic                 w_owner_valid;
  logic                 w_win_valid;
  logic [c_GRANT_W-1:0] w_win_id;
  logic [7:0]           w_win_data;
  logic                 w_win_last;
  logic                 w_transfer;
  logic                 w_lock_expire;
  logic [N_REQ-1:0]     w_ready;
  logic [c_CNT_W-1:0]   w_cnt_next;

  always_comb begin
    w_owner_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == c_GRANT_W'(i)) begin
        w_owner_valid = bus_if.req_valid[i];
      end
    end
  end

  // A held lock restricts the candidate set to the owner alone.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    if (lock_q) begin
      w_win_valid = w_owner_valid;
      w_win_id    = owner_q;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!w_win_valid && (((int'(ptr_q) + k) % N_REQ) == i) &&
              bus_if.req_valid[i]) begin
            w_win_valid = 1'b1;
            w_win_id    = c_GRANT_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    w_win_data = 8'h00;
    w_win_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win_id == c_GRANT_W'(i)) begin
        w_win_data = bus_if.req_data[8*i +: 8];
        w_win_last = bus_if.req_last[i];
      end
    end
  end

  assign w_transfer = (state_q == ST_IDLE) && w_win_valid && !rst_i;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ready[i] = w_transfer && (w_win_id == c_GRANT_W'(i));
    end
  end

  generate
    if (LOCK_IDLE_CLKS > 0) begin : g_lock_timeout
      localparam int c_IDLE_W = $clog2(LOCK_IDLE_CLKS + 1);

      logic [c_IDLE_W-1:0] idle_q, idle_d;
      logic                w_idle_run;

      assign w_idle_run    = (state_q == ST_IDLE) && lock_q && !w_owner_valid;
      assign w_lock_expire = w_idle_run && (idle_q == c_IDLE_W'(LOCK_IDLE_CLKS - 1));

      always_comb begin
        idle_d = '0;
        if (w_idle_run && !w_lock_expire) begin
          idle_d = idle_q + c_IDLE_W'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          idle_q <= '0;
        end else begin
          idle_q <= idle_d;
        end
      end
    end else begin : g_no_lock_timeout
      assign w_lock_expire = 1'b0;
    end
  endgenerate

  // Saturates so a long tx_busy stretch cannot wrap the frame timer.
  assign w_cnt_next = (cnt_q == c_CNT_LAST) ? cnt_q : cnt_q + c_CNT_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    sdata_d = sdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_transfer) begin
          sdata_d = w_win_data;
          grant_d = w_win_id;
          ptr_d   = w_win_id;
          owner_d = w_win_id;
          lock_d  = !w_win_last;
          state_d = ST_ISSUE;
        end else if (w_lock_expire) begin
          lock_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = w_cnt_next;
        if ((w_cnt_next == c_CNT_LAST) && !bus_if.tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= c_PTR_RST;
      grant_q <= '0;
      owner_q <= '0;
      lock_q  <= 1'b0;
      sdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      sdata_q <= sdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_if.req_ready  = w_ready;
  assign bus_if.tx_start   = (state_q == ST_ISSUE) && !rst_i;
  assign bus_if.sdata      = sdata_q;
  assign bus_if.grant_id   = grant_q;
  assign bus_if.sched_busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_scheduler : scoreboard bench for the UART TX round-robin scheduler
// Revision: 1.0
// ============================================================================
module tb_uart_tx_scheduler;

  localparam int N_REQ     = 4;
  localparam int CPHB      = 4;
  localparam int LOCK_IDLE = 16;
  localparam int FRAME     = CPHB * 20;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.N_REQ(N_REQ)) bus_if ();

  uart_tx_scheduler #(
    .N_REQ           (N_REQ),
    .CLK_PER_HALF_BIT(CPHB),
    .LOCK_IDLE_CLKS  (LOCK_IDLE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_if(bus_if)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [8:0] rq [N_REQ][$];
  logic [N_REQ-1:0] en = '0;
  exp_t       exp_q[$];
  int         acc_cyc_q[$];
  int         acc_cnt = 0;
  int         tx_cnt = 0;
  int         last_acc = 0;
  bit         have_acc = 0;
  bit         prev_tx = 0;
  bit         hold_v = 0;
  logic [7:0] hold_d = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor (negedge) and requester driver (just after posedge).
  initial begin : mon_drv
    logic [N_REQ-1:0] acc;
    logic [8:0]       f;
    exp_t             e;
    bus_if.req_valid = '0;
    bus_if.req_data  = '0;
    bus_if.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = '0;
      if (!rst) begin
        acc = bus_if.req_ready;
        checks++;
        if (($countones(acc) > 1) || ((acc & ~bus_if.req_valid) != '0)) begin
          errors++;
          $display("FAIL ready_onehot: req_ready=%b req_valid=%b, required one-hot within valid", acc, bus_if.req_valid);
        end
        if (hold_v) begin
          checks++;
          if (bus_if.sdata !== hold_d) begin
            errors++;
            $display("FAIL sdata_hold: sdata=%h, required %h", bus_if.sdata, hold_d);
          end
        end
        if (bus_if.tx_start === 1'b1) begin
          checks++;
          if (prev_tx || !have_acc || (cyc != last_acc + 1)) begin
            errors++;
            $display("FAIL tx_start_timing: tx_start at cycle %0d, required single pulse at %0d", cyc, last_acc + 1);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tx: sdata=%h grant_id=%0d, required no tx_start", bus_if.sdata, bus_if.grant_id);
          end else begin
            e = exp_q.pop_front();
            if ((bus_if.sdata !== e.data) || (bus_if.grant_id !== e.id)) begin
              errors++;
              $display("FAIL scoreboard: sdata=%h grant_id=%0d, required sdata=%h grant_id=%0d",
                       bus_if.sdata, bus_if.grant_id, e.data, e.id);
            end
          end
          tx_cnt++;
          hold_v = 1;
          hold_d = bus_if.sdata;
        end
        if (acc != '0) begin
          if (have_acc) begin
            checks++;
            if (cyc - last_acc < FRAME + 1) begin
              errors++;
              $display("FAIL accept_spacing: %0d cycles, required >= %0d", cyc - last_acc, FRAME + 1);
            end
          end
          have_acc = 1;
          last_acc = cyc;
          acc_cnt++;
          acc_cyc_q.push_back(cyc);
          hold_v = 0;
        end
        prev_tx = (bus_if.tx_start === 1'b1);
      end else begin
        prev_tx  = 0;
        hold_v   = 0;
        have_acc = 0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i] && (rq[i].size() > 0)) void'(rq[i].pop_front());
        f = (rq[i].size() > 0) ? rq[i][0] : 9'h000;
        bus_if.req_valid[i]       = en[i] && (rq[i].size() > 0);
        bus_if.req_data[8*i +: 8] = f[7:0];
        bus_if.req_last[i]        = f[8];
      end
    end
  end

  function automatic void rq_push(int id, logic [7:0] d, logic last);
    rq[id].push_back({last, d});
  endfunction

  function automatic void exp_push(int id, logic [7:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < N_REQ; i++) rq[i].delete();
    exp_q.delete();
    en = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_idle(int maxc);
    int n = 0;
    bit busy = 1;
    while (busy) begin
      @(negedge clk);
      busy = (exp_q.size() != 0) || (bus_if.sched_busy !== 1'b0);
      for (int i = 0; i < N_REQ; i++) if (rq[i].size() != 0) busy = 1;
      n++;
      if (busy && (n > maxc)) begin
        checks++;
        errors++;
        $display("FAIL wait_idle_timeout: %0d expected bytes left after %0d cycles, required 0", exp_q.size(), maxc);
        busy = 0;
      end
    end
  endtask

  task automatic wait_acc(int target, int maxc);
    int n = 0;
    while (acc_cnt < target) begin
      @(negedge clk);
      n++;
      if ((acc_cnt < target) && (n > maxc)) begin
        checks++;
        errors++;
        $display("FAIL wait_acc_timeout: accepts=%0d, required %0d", acc_cnt, target);
        break;
      end
    end
  endtask

  task automatic wait_tx(int maxc);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (bus_if.tx_start === 1'b1) break;
      n++;
      if (n > maxc) begin
        checks++;
        errors++;
        $display("FAIL wait_tx_timeout: no tx_start in %0d cycles, required one", maxc);
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (bus_if.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: %b, required 0000", bus_if.req_ready); end
    checks++; if (bus_if.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: %b, required 0", bus_if.tx_start); end
    checks++; if (bus_if.sdata !== 8'h00) begin errors++; $display("FAIL reset_sdata: %h, required 00", bus_if.sdata); end
    checks++; if (bus_if.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: %0d, required 0", bus_if.grant_id); end
    checks++; if (bus_if.sched_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", bus_if.sched_busy); end
  endtask

  task automatic test_single();
    int c;
    @(negedge clk);
    acc_cyc_q.delete();
    rq_push(0, 8'h41, 1'b1); exp_push(0, 8'h41);
    rq_push(0, 8'h42, 1'b1); exp_push(0, 8'h42);
    en = 4'b0001;
    c = cyc;
    wait_idle(400);
    checks++;
    if ((acc_cyc_q.size() != 2) || (acc_cyc_q[0] != c + 1)) begin
      errors++;
      $display("FAIL single_first_ready: accepts=%0d first=%0d, required 2 accepts first=%0d",
               acc_cyc_q.size(), (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : -1, c + 1);
    end else begin
      checks++;
      if (acc_cyc_q[1] - acc_cyc_q[0] != FRAME + 1) begin
        errors++;
        $display("FAIL single_spacing: %0d cycles, required %0d", acc_cyc_q[1] - acc_cyc_q[0], FRAME + 1);
      end
    end
  endtask

  task automatic test_round_robin();
    int a0;
    do_reset();
    @(negedge clk);
    a0 = acc_cnt;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N_REQ; i++) begin
        rq_push(i, 8'(32 + 16*r + i), 1'b1);
        exp_push(i, 8'(32 + 16*r + i));
      end
    end
    en = 4'b1111;
    wait_idle(1500);
    checks++;
    if (acc_cnt - a0 != 8) begin
      errors++;
      $display("FAIL rr_count: %0d accepts, required 8", acc_cnt - a0);
    end
  endtask

  task automatic test_lock();
    int a0;
    @(negedge clk);
    a0 = acc_cnt;
    rq_push(1, 8'h10, 1'b0); rq_push(1, 8'h11, 1'b0); rq_push(1, 8'h12, 1'b1);
    rq_push(2, 8'h22, 1'b1);
    rq_push(0, 8'h02, 1'b1);
    exp_push(1, 8'h10); exp_push(1, 8'h11); exp_push(1, 8'h12);
    exp_push(2, 8'h22); exp_push(0, 8'h02);
    en = 4'b0010;
    wait_acc(a0 + 1, 50);
    en = 4'b0111;
    wait_idle(1000);
    checks++;
    if (acc_cnt - a0 != 5) begin
      errors++;
      $display("FAIL lock_count: %0d accepts, required 5", acc_cnt - a0);
    end
  endtask

  task automatic test_busy();
    int f;
    int tx0;
    @(negedge clk);
    acc_cyc_q.delete();
    rq_push(3, 8'h5A, 1'b1); exp_push(3, 8'h5A);
    rq_push(3, 8'hA5, 1'b1); exp_push(3, 8'hA5);
    en = 4'b1000;
    wait_tx(50);
    @(posedge clk);
    #2;
    tx0 = tx_cnt;
    bus_if.tx_busy = 1'b1;
    repeat (200) @(posedge clk);
    #2;
    bus_if.tx_busy = 1'b0;
    f = cyc;
    wait_idle(400);
    checks++;
    if ((acc_cyc_q.size() != 2) || (acc_cyc_q[1] != f + 1)) begin
      errors++;
      $display("FAIL busy_release: accepts=%0d second=%0d, required 2 accepts second=%0d",
               acc_cyc_q.size(), (acc_cyc_q.size() > 1) ? acc_cyc_q[1] : -1, f + 1);
    end
    checks++;
    if (tx_cnt - tx0 != 1) begin
      errors++;
      $display("FAIL busy_tx_count: %0d tx_start after busy, required 1", tx_cnt - tx0);
    end
  endtask

  task automatic test_lock_timeout();
    int a0;
    @(negedge clk);
    acc_cyc_q.delete();
    a0 = acc_cnt;
    rq_push(3, 8'h77, 1'b0); exp_push(3, 8'h77);
    rq_push(0, 8'h01, 1'b1); exp_push(0, 8'h01);
    en = 4'b1000;
    wait_acc(a0 + 1, 50);
    en = 4'b1001;
    wait_idle(500);
    checks++;
    if ((acc_cyc_q.size() != 2) || (acc_cyc_q[1] - acc_cyc_q[0] != FRAME + 1 + LOCK_IDLE)) begin
      errors++;
      $display("FAIL lock_timeout: accepts=%0d gap=%0d, required 2 accepts gap=%0d", acc_cyc_q.size(),
               (acc_cyc_q.size() > 1) ? acc_cyc_q[1] - acc_cyc_q[0] : -1, FRAME + 1 + LOCK_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rq_push(2, 8'h33, 1'b0); exp_push(2, 8'h33);
    rq_push(2, 8'h34, 1'b1);
    en = 4'b0100;
    wait_tx(50);
    repeat (10) @(posedge clk);
    do_reset();
    @(negedge clk);
    checks++; if (bus_if.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: %b, required 0000", bus_if.req_ready); end
    checks++; if (bus_if.tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start: %b, required 0", bus_if.tx_start); end
    checks++; if (bus_if.sdata !== 8'h00) begin errors++; $display("FAIL mid_sdata: %h, required 00", bus_if.sdata); end
    checks++; if (bus_if.grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant: %0d, required 0", bus_if.grant_id); end
    checks++; if (bus_if.sched_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: %b, required 0", bus_if.sched_busy); end
    rq_push(0, 8'h01, 1'b1);
    rq_push(2, 8'h02, 1'b1);
    rq_push(3, 8'h03, 1'b1);
    exp_push(0, 8'h01); exp_push(2, 8'h02); exp_push(3, 8'h03);
    en = 4'b1101;
    wait_idle(600);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1;
    bus_if.tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_busy();
    test_lock_timeout();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter between N_REQ byte requesters using round-robin arbitration. Drives the transmitter's tx_start/sdata and paces frames.
- Supports multi-byte messages: a requester keeps the grant until it sends a byte flagged last, so messages from different requesters never interleave.
- Sits between the core-side debug/output sources and the UART TX instance.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CLK_PER_HALF_BIT, 5208, must equal the transmitter's setting; FRAME_CLKS = CLK_PER_HALF_BIT*20 (one 10-bit frame)
- LOCK_IDLE_CLKS, 0, idle cycles after which an unfinished message lock is dropped; 0 = never drop

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has a byte
- req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i]
- req_last  in  N_REQ  byte of requester i ends its message
- req_ready  out  N_REQ  byte of requester i accepted this cycle
- tx_start  out  1  one-cycle start pulse to the transmitter
- sdata  out  8  byte to the transmitter, stable from tx_start until the next accept
- tx_busy  in  1  transmitter busy
- grant_id  out  max(1,$clog2(N_REQ))  requester whose byte is in flight
- sched_busy  out  1  high in ISSUE/WAIT

Behaviour:
- One clock; reset is synchronous and active-high. Reset dominates every other input in the same cycle.
- Reset values: tx_start=0, sdata=0, req_ready=0, grant_id=0, sched_busy=0, state=IDLE, lock=0, round-robin pointer=N_REQ-1 (so requester 0 wins first).
- Reset mid-frame: return to IDLE, clear the lock, drop any pending tx_start.

States:
- IDLE:
  - Winner when unlocked: first i with req_valid[i]=1, searching from pointer+1 upward with wrap.
  - Winner when locked: the lock owner only; other requesters get nothing even if valid.
  - req_ready[winner]=1 combinationally in the same cycle. The byte transfers on that edge.
  - On transfer: capture req_data into sdata, set grant_id=winner, pointer=winner, go to ISSUE.
  - Lock after transfer: req_last=0 -> lock=1, owner=winner; req_last=1 -> lock=0.
- ISSUE: tx_start=1 for exactly this cycle; frame counter := 0; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - Go to IDLE when counter >= FRAME_CLKS-1 AND tx_busy=0.
  - If tx_busy is still high after the timer expires, stay in WAIT; the counter saturates and does not wrap.
- req_ready is 0 outside IDLE. It is one-hot or zero, and is never asserted toward a requester with req_valid=0.

Lock timeout:
- Applies only when LOCK_IDLE_CLKS>0.
- An idle counter runs while in IDLE, locked, with the owner's req_valid=0. It resets whenever the owner's valid is 1 or the scheduler leaves IDLE.
- When it reaches LOCK_IDLE_CLKS, clear the lock. Normal arbitration resumes the next cycle.

Timing:
- Valid seen in IDLE at cycle t -> req_ready at t; tx_start at t+1; IDLE again at t+1+FRAME_CLKS (tx_busy low).
- Minimum accept-to-accept spacing is FRAME_CLKS+1.
- Single requester in IDLE: it is granted regardless of the pointer.
- grant_id and sdata hold their values after WAIT until the next transfer.

Test Plan:
- CLK_PER_HALF_BIT=4 (FRAME_CLKS=80), reset, then req_valid[0]=1, data 0x41, last=1 -> req_ready[0] in the same cycle, tx_start exactly one cycle later with sdata=0x41, next ready no earlier than 81 cycles after the first.
- All 4 valid continuously, all last=1 -> grants in order 0,1,2,3,0; each req_ready one-hot.
- Requester 1 sends 0x10(last=0), 0x11(last=0), 0x12(last=1) while requesters 0 and 2 are valid -> the three bytes go out consecutively, then requester 2 wins, then 0.
- Hold tx_busy=1 for 200 cycles after tx_start -> scheduler stays in WAIT until tx_busy falls, then accepts the next byte in the cycle after WAIT exits; no extra tx_start.
- LOCK_IDLE_CLKS=16: requester 3 sends a last=0 byte then drops valid, requester 0 valid -> requester 0 is not granted until 16 idle cycles have elapsed, then granted.
- Assert reset during WAIT with the lock held -> next cycle all outputs are at reset values; requester 0 wins the next arbitration.
